// File: rtl/load_store_unit.sv
// load_store_unit
//   MEM-stage load/store engine. Accepts one EX/MEM access in IDLE, runs a
//   req/ready transaction on the data bus, formats the returned load data and
//   holds the pipeline while the bus is busy. Misaligned and illegal accesses
//   fault immediately in IDLE without touching the bus. A bus that never
//   answers faults after MAX_WAIT BUSY cycles.
//
// Ports
//   clk_i, reset_i            clock, synchronous active-high reset
//   valid_i                   EX/MEM slot holds a live instruction
//   mem_read_i, mem_write_i   load / store
//   funct3_i                  width/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
//   addr_i, wdata_i           byte address, store data (rs2)
//   flush_i                   kill the access presented this cycle (IDLE only)
//   stall_o                   hold IF..MEM
//   rdata_o, rdata_valid_o    formatted load data, completion pulse
//   fault_o, fault_cause_o    fault pulse; 01 misaligned, 10 timeout, 11 illegal
//   bus_req_o .. bus_wdata_o  data bus request side
//   bus_ready_i, bus_rdata_i  data bus response side
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for an access; checks run combinationally here
// BUSY  | bus_req high, waiting for bus_ready or wait counter to expire
// DONE  | one-cycle completion: rdata_valid or timeout fault pulse

module load_store_unit #(
  parameter int XLEN     = 32,
  parameter int MAX_WAIT = 16
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            valid_i,
  input  logic            mem_read_i,
  input  logic            mem_write_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] addr_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic            flush_i,
  output logic            stall_o,
  output logic [XLEN-1:0] rdata_o,
  output logic            rdata_valid_o,
  output logic            fault_o,
  output logic [1:0]      fault_cause_o,
  output logic            bus_req_o,
  output logic            bus_we_o,
  output logic [XLEN-1:0] bus_addr_o,
  output logic [3:0]      bus_be_o,
  output logic [XLEN-1:0] bus_wdata_o,
  input  logic            bus_ready_i,
  input  logic [XLEN-1:0] bus_rdata_i
);

  localparam int WW = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic            we_q, we_d;
  logic [3:0]      be_q, be_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [2:0]      f3_q, f3_d;
  logic [WW-1:0]   wait_q, wait_d;
  logic            timeout_q, timeout_d;
  logic [XLEN-1:0] rdata_q, rdata_d;

  logic            req, ld_legal, st_legal, illegal, misaligned, accept;
  logic [3:0]      be_new;
  logic [XLEN-1:0] wdata_new, lane, load_fmt;

  // ---------------- request decode (IDLE) ----------------
  always_comb begin
    req = valid_i & (mem_read_i | mem_write_i) & ~flush_i;

    ld_legal = 1'b0;
    case (funct3_i)
      3'b000, 3'b001, 3'b010, 3'b100, 3'b101: ld_legal = 1'b1;
      default:                                ld_legal = 1'b0;
    endcase
    st_legal = (funct3_i[2] == 1'b0) && (funct3_i[1:0] != 2'b11);

    illegal = (mem_read_i & mem_write_i) |
              (mem_read_i ? ~ld_legal : ~st_legal);
    misaligned = ((funct3_i[1:0] == 2'b01) & addr_i[0]) |
                 ((funct3_i[1:0] == 2'b10) & (addr_i[1:0] != 2'b00));

    accept = (state_q == S_IDLE) & req & ~illegal & ~misaligned;

    be_new    = 4'b1111;
    wdata_new = wdata_i;
    case (funct3_i[1:0])
      2'b00: begin
        be_new    = 4'b0001 << addr_i[1:0];
        wdata_new = {4{wdata_i[7:0]}};
      end
      2'b01: begin
        be_new    = addr_i[1] ? 4'b1100 : 4'b0011;
        wdata_new = {2{wdata_i[15:0]}};
      end
      default: begin
        be_new    = 4'b1111;
        wdata_new = wdata_i;
      end
    endcase
  end

  // ---------------- load formatting ----------------
  always_comb begin
    // Shift the addressed lane down to bit 0, then extend.
    lane     = bus_rdata_i >> {addr_q[1:0], 3'b000};
    load_fmt = bus_rdata_i;
    case (f3_q)
      3'b000:  load_fmt = {{24{lane[7]}}, lane[7:0]};
      3'b100:  load_fmt = {24'b0, lane[7:0]};
      3'b001:  load_fmt = {{16{lane[15]}}, lane[15:0]};
      3'b101:  load_fmt = {16'b0, lane[15:0]};
      default: load_fmt = bus_rdata_i;
    endcase
  end

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      we_q      <= 1'b0;
      be_q      <= '0;
      wdata_q   <= '0;
      f3_q      <= '0;
      wait_q    <= '0;
      timeout_q <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      we_q      <= we_d;
      be_q      <= be_d;
      wdata_q   <= wdata_d;
      f3_q      <= f3_d;
      wait_q    <= wait_d;
      timeout_q <= timeout_d;
      rdata_q   <= rdata_d;
    end
  end

  // ---------------- FSM: next state + datapath ----------------
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    we_d      = we_q;
    be_d      = be_q;
    wdata_d   = wdata_q;
    f3_d      = f3_q;
    wait_d    = wait_q;
    timeout_d = timeout_q;
    rdata_d   = rdata_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d   = S_BUSY;
          addr_d    = addr_i;
          we_d      = mem_write_i;
          be_d      = be_new;
          wdata_d   = wdata_new;
          f3_d      = funct3_i;
          // Down-counter: terminal count 0 marks the last allowed BUSY cycle.
          wait_d    = WW'(MAX_WAIT - 1);
          timeout_d = 1'b0;
        end
      end
      S_BUSY: begin
        if (bus_ready_i) begin
          state_d = S_DONE;
          rdata_d = we_q ? '0 : load_fmt;
        end else if (wait_q == '0) begin
          state_d   = S_DONE;
          timeout_d = 1'b1;
          rdata_d   = '0;
        end else begin
          wait_d = wait_q - 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        wait_d  = '0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    stall_o       = 1'b0;
    rdata_valid_o = 1'b0;
    fault_o       = 1'b0;
    fault_cause_o = 2'b00;
    bus_req_o     = 1'b0;
    bus_we_o      = 1'b0;
    bus_addr_o    = '0;
    bus_be_o      = '0;
    bus_wdata_o   = '0;

    case (state_q)
      S_IDLE: begin
        stall_o = accept;
        if (req && (illegal || misaligned)) begin
          fault_o       = 1'b1;
          fault_cause_o = illegal ? 2'b11 : 2'b01;
        end
      end
      S_BUSY: begin
        stall_o     = 1'b1;
        bus_req_o   = 1'b1;
        bus_we_o    = we_q;
        bus_addr_o  = {addr_q[XLEN-1:2], 2'b00};
        bus_be_o    = be_q;
        bus_wdata_o = wdata_q;
      end
      S_DONE: begin
        if (timeout_q) begin
          fault_o       = 1'b1;
          fault_cause_o = 2'b10;
        end else begin
          rdata_valid_o = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign rdata_o = rdata_q;

endmodule
